// File: rtl/seq_alu_pkg.sv
// Shared types for the registered sequential ALU: opcodes, FSM states and the flag bundle.
package seq_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_NOR = 4'd4,
      OP_XOR = 4'd5,
      OP_SLL = 4'd6,
      OP_SRL = 4'd7,
      OP_SRA = 4'd8,
      OP_MUL = 4'd9
   } op_e;

   // Highest legal opcode; anything above it completes as an illegal op.
   localparam logic [3:0] OP_LAST = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULB = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
      logic err;
   } flag_t;

   function automatic logic is_illegal(input logic [3:0] op);
      return op > OP_LAST;
   endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, multiplier LSB first.
module seq_alu_mul #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_lo,
   output logic             prod_hi_nz
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_count;
   logic               r_busy;
   logic [2*WIDTH-1:0] w_acc_next;

   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   // done flags the final step so the product can be captured on that same edge.
   assign busy       = r_busy;
   assign done       = r_busy && (r_count == '0);
   assign prod_lo    = w_acc_next[WIDTH-1:0];
   assign prod_hi_nz = |w_acc_next[2*WIDTH-1:WIDTH];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_count  <= '0;
         r_busy   <= 1'b0;
      end else if (start) begin
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, a};
         r_mplier <= b;
         r_count  <= CW'(WIDTH - 1);
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         if (r_count == '0) begin
            r_busy <= 1'b0;
         end else begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready on both sides; single-cycle ops latch on accept, MUL iterates.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf,
   output logic             err
);

   localparam int MSB = WIDTH - 1;

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_result;
   flag_t            r_flags;

   logic             w_accept;
   logic             w_is_mul;
   logic             w_mul_start;
   logic             w_latch_alu;
   logic             w_latch_mul;
   logic             w_mul_busy;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_lo;
   logic             w_mul_hi_nz;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_dif;
   logic [SHW-1:0]   w_shamt;
   logic             w_shift_big;
   logic [WIDTH-1:0] w_res;
   logic             w_carry;
   logic             w_ovf;
   logic             w_err;

   assign w_accept = in_valid && in_ready;
   assign w_is_mul = (op == OP_MUL);

   seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (w_mul_start),
      .a          (a),
      .b          (b),
      .busy       (w_mul_busy),
      .done       (w_mul_done),
      .prod_lo    (w_mul_lo),
      .prod_hi_nz (w_mul_hi_nz)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_next = w_is_mul ? MULB : DONE;
         MULB: begin
            if (w_mul_done)       w_state_next = DONE;
            else if (!w_mul_busy) w_state_next = IDLE;
         end
         DONE: if (out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (r_state == IDLE);
      out_valid   = (r_state == DONE);
      w_mul_start = w_accept && w_is_mul;
      w_latch_alu = w_accept && !w_is_mul;
      w_latch_mul = (r_state == MULB) && w_mul_done;
   end

   assign w_sum       = {1'b0, a} + {1'b0, b};
   assign w_dif       = {1'b0, a} - {1'b0, b};
   assign w_shamt     = b[SHW-1:0];
   assign w_shift_big = |b[WIDTH-1:SHW];

   // Single-cycle datapath; out-of-range shift amounts saturate instead of wrapping.
   always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      w_err   = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            w_res   = w_sum[MSB:0];
            w_carry = w_sum[WIDTH];
            w_ovf   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            w_res   = w_dif[MSB:0];
            w_carry = w_dif[WIDTH];
            w_ovf   = (a[MSB] != b[MSB]) && (w_dif[MSB] != a[MSB]);
         end
         OP_AND: w_res = a & b;
         OP_OR:  w_res = a | b;
         OP_NOR: w_res = ~(a | b);
         OP_XOR: w_res = a ^ b;
         OP_SLL: w_res = w_shift_big ? '0 : (a << w_shamt);
         OP_SRL: w_res = w_shift_big ? '0 : (a >> w_shamt);
         OP_SRA: w_res = w_shift_big ? {WIDTH{a[MSB]}} : WIDTH'($signed(a) >>> w_shamt);
         OP_MUL: w_res = '0;
         default: w_err = is_illegal(op);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_flags  <= '0;
      end else if (w_latch_alu) begin
         r_result      <= w_res;
         r_flags.zero  <= (w_res == '0);
         r_flags.neg   <= w_res[MSB];
         r_flags.carry <= w_carry;
         r_flags.ovf   <= w_ovf;
         r_flags.err   <= w_err;
      end else if (w_latch_mul) begin
         r_result      <= w_mul_lo;
         r_flags.zero  <= (w_mul_lo == '0);
         r_flags.neg   <= w_mul_lo[MSB];
         r_flags.carry <= w_mul_hi_nz;
         r_flags.ovf   <= 1'b0;
         r_flags.err   <= 1'b0;
      end
   end

   assign result = r_result;
   assign zero   = r_flags.zero;
   assign neg    = r_flags.neg;
   assign carry  = r_flags.carry;
   assign ovf    = r_flags.ovf;
   assign err    = r_flags.err;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=16, plus back-pressure and mid-MUL reset sequences.
module tb_seq_alu;
   import seq_alu_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [3:0]   op = 4'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] result;
   logic         zero, neg, carry, ovf, err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [4:0]   flg;   // {zero, neg, carry, ovf, err}
      int           lat;
   } vec_t;

   vec_t vecs[23];

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .neg       (neg),
      .carry     (carry),
      .ovf       (ovf),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Presents one operation, returns the edge count from accept to the first edge with
   // out_valid high, and how many of those cycles showed in_ready high.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int rdy_hi);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); op = 4'($urandom);
      lat = 1; rdy_hi = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_hi++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take_output(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, "_ov_after_xfer"}, 32'(out_valid), 32'd0);
      check({name, "_ir_after_xfer"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int lat, rdy;
      logic [W-1:0] held_res;
      logic [4:0]   held_flg;

      vecs[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 5'b01010, 1};
      vecs[1]  = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 5'b01100, 1};
      vecs[2]  = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 5'b10000, 1};
      vecs[3]  = '{OP_SRA, 16'h8000, 16'h0004, 16'hF800, 5'b01000, 1};
      vecs[4]  = '{OP_SRL, 16'h8000, 16'h0010, 16'h0000, 5'b10000, 1};
      vecs[5]  = '{OP_SLL, 16'h0001, 16'h000F, 16'h8000, 5'b01000, 1};
      vecs[6]  = '{OP_MUL, 16'h0100, 16'h0101, 16'h0100, 5'b00100, 17};
      vecs[7]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 5'b10100, 1};
      vecs[8]  = '{OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 5'b00000, 1};
      vecs[9]  = '{OP_OR,  16'hF0F0, 16'h0F00, 16'hFFF0, 5'b01000, 1};
      vecs[10] = '{OP_NOR, 16'h0F0F, 16'h00F0, 16'hF000, 5'b01000, 1};
      vecs[11] = '{OP_XOR, 16'hAAAA, 16'hFFFF, 16'h5555, 5'b00000, 1};
      vecs[12] = '{OP_SRA, 16'h8000, 16'h0010, 16'hFFFF, 5'b01000, 1};
      vecs[13] = '{OP_SRA, 16'h4000, 16'h0020, 16'h0000, 5'b10000, 1};
      vecs[14] = '{OP_MUL, 16'h0003, 16'h0005, 16'h000F, 5'b00000, 17};
      vecs[15] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 5'b00100, 17};
      vecs[16] = '{4'd12,  16'h1234, 16'h5678, 16'h0000, 5'b10001, 1};
      vecs[17] = '{4'd15,  16'hFFFF, 16'hFFFF, 16'h0000, 5'b10001, 1};
      vecs[18] = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 5'b00010, 1};
      vecs[19] = '{OP_SRL, 16'h8000, 16'h0004, 16'h0800, 5'b00000, 1};
      vecs[20] = '{OP_SLL, 16'h0001, 16'h0011, 16'h0000, 5'b10000, 1};
      vecs[21] = '{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 5'b10110, 1};
      vecs[22] = '{OP_MUL, 16'h8000, 16'h0002, 16'h0000, 5'b10100, 17};

      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result",    32'(result),    32'd0);
      check("rst_flags",     32'({zero, neg, carry, ovf, err}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, rdy);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("v%0d_result", i),  32'(result), 32'(vecs[i].res));
         check($sformatf("v%0d_flags", i),   32'({zero, neg, carry, ovf, err}), 32'(vecs[i].flg));
         if (vecs[i].op == OP_MUL) check($sformatf("v%0d_in_ready_busy", i), 32'(rdy), 32'd0);
         take_output($sformatf("v%0d", i));
      end

      // Back-pressure: hold the result for 5 cycles while a new request waits.
      issue(OP_XOR, 16'h00FF, 16'h0F0F, lat, rdy);
      check("bp_latency", 32'(lat), 32'd1);
      held_res = result;
      held_flg = {zero, neg, carry, ovf, err};
      check("bp_result", 32'(held_res), 32'h0FF0);
      op = OP_ADD; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp_hold%0d_result", c), 32'(result), 32'(held_res));
         check($sformatf("bp_hold%0d_flags", c), 32'({zero, neg, carry, ovf, err}), 32'(held_flg));
         check($sformatf("bp_hold%0d_ov", c), 32'(out_valid), 32'd1);
         check($sformatf("bp_hold%0d_ir", c), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_xfer_ov", 32'(out_valid), 32'd0);
      check("bp_xfer_ir", 32'(in_ready),  32'd1);
      check("bp_xfer_result", 32'(result), 32'h0FF0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_next_ov", 32'(out_valid), 32'd1);
      check("bp_next_result", 32'(result), 32'h0002);
      take_output("bp_next");

      // Reset pulsed in the middle of a multiply.
      @(negedge clk);
      op = OP_MUL; a = 16'h1234; b = 16'h00FF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_in_ready",  32'(in_ready),  32'd1);
      check("mrst_result",    32'(result),    32'd0);
      check("mrst_flags",     32'({zero, neg, carry, ovf, err}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(OP_ADD, 16'h0002, 16'h0003, lat, rdy);
      check("mrst_add_latency", 32'(lat), 32'd1);
      check("mrst_add_result",  32'(result), 32'h0005);
      check("mrst_add_flags",   32'({zero, neg, carry, ovf, err}), 32'd0);
      take_output("mrst_add");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU with a valid/ready handshake on both sides. It extends the datapath's 16-bit combinational ALU with a configurable width, a 4-bit opcode, arithmetic shift, an iterative shift-add multiplier and a full flag set (zero, negative, carry, overflow, illegal-op). It sits between the operand-fetch stage and write-back. The output stage holds each result until the consumer accepts it.

## Interface
- WIDTH, 16: operand and result width, ≥ 4, power of two.
- SHW, $clog2(WIDTH): number of B bits used as the shift amount (derived; do not override).
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept an operation.
- op  in  4  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].
- carry  out  1  carry, borrow or product overflow.
- ovf  out  1  signed overflow.
- err  out  1  illegal opcode.

## Operation
- Opcodes:
  - 0 ADD: a+b; carry = carry-out; ovf = signed overflow.
  - 1 SUB: a−b; carry = borrow (a<b unsigned); ovf = signed overflow.
  - 2 AND, 3 OR, 4 NOR, 5 XOR: bitwise.
  - 6 SLL, 7 SRL: logical shift; 8 SRA: arithmetic shift.
  - 9 MUL: low WIDTH bits of unsigned a*b; carry = 1 if any high product bit is nonzero.
- Shift amount is b[SHW-1:0]. If any b bit at or above SHW is set, SLL/SRL return 0 and SRA returns all sign bits.
- carry and ovf are 0 for every opcode not listed against them; ovf is 0 for MUL.
- Opcodes 10–15: result 0, zero=1, err=1, all other flags 0. They complete with single-cycle latency.
- States:
  - IDLE: in_ready=1. On accept (in_valid && in_ready): a single-cycle op computes and latches result and flags, then goes to DONE. MUL latches a, b and counter=WIDTH−1, clears the accumulator, then goes to MULB.
  - MULB: one shift-add step per cycle, LSB of multiplier first. After the step with counter=0, latch the result and flags and go to DONE.
  - DONE: out_valid=1. If out_ready, go to IDLE; otherwise hold result and flags unchanged.
- in_ready is 0 in MULB and DONE. There is no overlap between operations; throughput is one operation per 2 cycles minimum.
- a, b and op are sampled only on accept. Changes on the inputs at any other time have no effect.
- Reset (any state, including mid-MUL): state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0, counter and accumulator=0. The in-flight operation is dropped.

## Timing
- Accept on edge k: single-cycle op has out_valid=1 after edge k+1; MUL has out_valid=1 after edge k+WIDTH+1 (WIDTH step edges, then the transfer into DONE).
- Output transfer happens on an edge with out_valid && out_ready. in_ready rises after that edge, so the next accept is possible at edge k'+1 at the earliest.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.
- Flags change only when result is latched.

## Structure
- Package seq_alu_pkg:
  - op_e enum: OP_ADD … OP_MUL, with OP_LAST=9.
  - state_e enum: IDLE, MULB, DONE.
  - flag struct: zero, neg, carry, ovf, err.
- Sub-module seq_alu_mul: iterative shift-add multiplier.
  - Ports: start, a, b, busy, done, prod_lo, prod_hi_nz.
  - The FSM in seq_alu drives it; the single-cycle datapath is combinational logic inside seq_alu.

## Test plan
- WIDTH=16, ADD a=0x7FFF b=0x0001 → result 0x8000, ovf=1, neg=1, carry=0, out_valid after 1 cycle.
- SUB a=0x0003 b=0x0005 → result 0xFFFE, carry=1, ovf=0. Then SUB a=5 b=5 → result 0, zero=1.
- SRA a=0x8000 b=0x0004 → 0xF800. SRL a=0x8000 b=0x0010 → 0. SLL a=1 b=0x000F → 0x8000.
- MUL a=0x0100 b=0x0101 → result 0x0100, carry=1. out_valid exactly 17 cycles after accept; in_ready=0 throughout.
- Back-pressure: out_ready=0 for 5 cycles after any result → result and flags stable, in_ready=0; a new in_valid is not accepted until the cycle after the output transfer.
- Illegal op=12 → result 0, err=1, zero=1. Then rst_n pulsed low mid-MUL → out_valid=0, result=0, in_ready=1 immediately; the next ADD completes normally.
